regfile_write_arbiter: RTL and testbench
========================================

# regfile_write_arbiter

Shares the CPU2 register-file write port between the writeback (WB) stage and the external loader port (the generalWrite/tempWriteSelect/tempWriteData path) used to preload registers. WB has fixed priority. A loader kept waiting too long triggers a pipeline stall request so the loader is guaranteed forward progress. All register-file write outputs are registered, so the block sits directly in front of the register file's single write port.

## Interface
- DATA_W, 32, write data width
- ADDR_W, 6, register select width (matches tempWriteSelect)
- MAX_WAIT, 4, consecutive WB-won cycles before stall_req is raised; legal range 1..15
- Clk  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-low; clears all state immediately
- wb_we  in  1  WB stage write enable
- wb_addr  in  ADDR_W  WB destination register
- wb_data  in  DATA_W  WB write data
- ld_req  in  1  loader request; held until ld_ack is seen
- ld_addr  in  ADDR_W  loader destination register
- ld_data  in  DATA_W  loader write data
- ld_ack  out  1  one-cycle pulse; loader write is committed
- stall_req  out  1  asks the pipeline to freeze; the pipeline forces wb_we=0 while it is high
- rf_we  out  1  register-file write enable
- rf_addr  out  ADDR_W  register-file write select
- rf_data  out  DATA_W  register-file write data
- err  out  1  sticky protocol error: wb_we seen while stall_req was high

## Operation
- Reset (Reset=0): state IDLE, wait counter 0. All outputs are 0: rf_we, rf_addr, rf_data, ld_ack, stall_req, err.
- Effective loader request: ld_req & ~ld_ack. The loader request is masked during the ack cycle.
- A winner is selected each cycle and registered. The WB winner drives rf_* from the wb_* inputs; the loader winner drives rf_* from the ld_* inputs and sets ld_ack. With no winner, rf_we=0 and rf_addr/rf_data hold their previous values.
- Writes to address 0 are suppressed (rf_we stays 0) for both sources. A loader write to address 0 is still acked.
- States:
  - IDLE:
    - effective ld_req and no wb_we → loader wins; stay IDLE.
    - effective ld_req and wb_we → WB wins; counter=1; go to WAIT (or STALL if MAX_WAIT=1).
    - otherwise → WB wins if wb_we.
  - WAIT:
    - no wb_we → loader wins; counter=0; go to IDLE.
    - wb_we → WB wins; counter++. When counter reaches MAX_WAIT, go to STALL.
    - ld_req dropped → return to IDLE, counter=0, no ack.
  - STALL: stall_req=1.
    - no wb_we → loader wins; go to IDLE; stall_req=0 next cycle.
    - wb_we → WB still wins (data is never lost); err set; stay STALL.
    - ld_req dropped → go to IDLE, no ack.
- err clears only on reset.

## Timing
- Latency: a winner selected in cycle N shows rf_we/rf_addr/rf_data (and ld_ack for the loader) in cycle N+1.
- Loader throughput: at most one write every 2 cycles, because of the ack mask.
- stall_req is registered. It rises the cycle after the MAX_WAIT-th WB win and falls the cycle after the loader grant.
- Simultaneous requests: WB always wins. The loader waits at most MAX_WAIT WB-won cycles, plus 1 stall cycle when the pipeline honours stall_req.
- Reset asserted mid-operation: any pending grant is discarded, with no ack and no rf_we. Outputs go to 0 asynchronously.
- The ld_addr/ld_data values sampled are those present in the grant cycle.

## Test plan
- Reset release, idle inputs → all outputs stay 0 for 10 cycles; state IDLE.
- ld_req=1, ld_addr=3, ld_data=4, wb_we=0 → next cycle rf_we=1, rf_addr=3, rf_data=4, ld_ack=1; no second write while ld_req is still held during ack.
- wb_we=1 (addr 5, data 0xA5) with ld_req=1 (addr 7) for 2 cycles, then wb_we=0 → two WB writes to 5, then a loader write to 7 with ld_ack; stall_req stays 0.
- MAX_WAIT=4, wb_we held at 1 with ld_req pending → stall_req=1 after the 4th WB write. Drop wb_we → loader write and ld_ack next cycle; stall_req=0 one cycle later.
- While stall_req=1, assert wb_we=1 → WB write still occurs, err=1 and stays 1 until reset.
- Loader write to address 0 → ld_ack=1, rf_we=0. Assert Reset=0 mid-WAIT → all outputs 0 immediately, no ack after release.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Arbitrates the single register-file write port between the WB stage (fixed priority)
// and the preload loader. A loader starved for MAX_WAIT WB wins raises a stall request.
module regfile_write_arbiter #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 6,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_we,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ack,
  output logic              stall_req,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_data,
  output logic              err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    STALL = 2'd2
  } state_t;

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  state_t              state_r, state_s;
  logic [3:0]          wait_cnt_r, wait_cnt_s;
  logic                grant_wb_s, grant_ld_s, eff_ld_s;
  logic [ADDR_W-1:0]   sel_addr_s;
  logic [DATA_W-1:0]   sel_data_s;
  logic                ld_ack_r, stall_req_r, rf_we_r, err_r;
  logic [ADDR_W-1:0]   rf_addr_r;
  logic [DATA_W-1:0]   rf_data_r;

  // Next-state and grant selection; WB always wins when it writes.
  always_comb begin
    state_s    = state_r;
    wait_cnt_s = wait_cnt_r;
    grant_wb_s = 1'b0;
    grant_ld_s = 1'b0;
    eff_ld_s   = ld_req & ~ld_ack_r;
    case (state_r)
      IDLE: begin
        if (eff_ld_s && wb_we) begin
          grant_wb_s = 1'b1;
          wait_cnt_s = 4'd1;
          state_s    = (MAX_WAIT_C == 4'd1) ? STALL : WAIT;
        end else if (eff_ld_s) begin
          grant_ld_s = 1'b1;
        end else begin
          grant_wb_s = wb_we;
        end
      end
      WAIT: begin
        if (!eff_ld_s) begin
          grant_wb_s = wb_we;
          wait_cnt_s = 4'd0;
          state_s    = IDLE;
        end else if (!wb_we) begin
          grant_ld_s = 1'b1;
          wait_cnt_s = 4'd0;
          state_s    = IDLE;
        end else begin
          grant_wb_s = 1'b1;
          wait_cnt_s = wait_cnt_r + 4'd1;
          if (wait_cnt_s >= MAX_WAIT_C) begin
            state_s = STALL;
          end else begin
            state_s = WAIT;
          end
        end
      end
      STALL: begin
        // A WB write during stall is still performed so no data is lost.
        if (!eff_ld_s) begin
          grant_wb_s = wb_we;
          wait_cnt_s = 4'd0;
          state_s    = IDLE;
        end else if (!wb_we) begin
          grant_ld_s = 1'b1;
          wait_cnt_s = 4'd0;
          state_s    = IDLE;
        end else begin
          grant_wb_s = 1'b1;
        end
      end
      default: begin
        state_s    = IDLE;
        wait_cnt_s = 4'd0;
      end
    endcase
    if (grant_ld_s) begin
      sel_addr_s = ld_addr;
      sel_data_s = ld_data;
    end else begin
      sel_addr_s = wb_addr;
      sel_data_s = wb_data;
    end
  end

  // State, wait counter and registered write-port outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      wait_cnt_r  <= 4'd0;
      ld_ack_r    <= 1'b0;
      stall_req_r <= 1'b0;
      rf_we_r     <= 1'b0;
      rf_addr_r   <= {ADDR_W{1'b0}};
      rf_data_r   <= {DATA_W{1'b0}};
      err_r       <= 1'b0;
    end else begin
      state_r     <= state_s;
      wait_cnt_r  <= wait_cnt_s;
      ld_ack_r    <= grant_ld_s;
      stall_req_r <= (state_s == STALL);
      rf_we_r     <= (grant_wb_s | grant_ld_s) && (sel_addr_s != {ADDR_W{1'b0}});
      if (grant_wb_s || grant_ld_s) begin
        rf_addr_r <= sel_addr_s;
        rf_data_r <= sel_data_s;
      end
      err_r <= err_r | (wb_we & stall_req_r);
    end
  end

  assign ld_ack    = ld_ack_r;
  assign stall_req = stall_req_r;
  assign rf_we     = rf_we_r;
  assign rf_addr   = rf_addr_r;
  assign rf_data   = rf_data_r;
  assign err       = err_r;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed and randomized checks of regfile_write_arbiter against a starvation-count model.
module tb_regfile_write_arbiter;
  localparam int DW = 32;
  localparam int AW = 6;
  localparam int MW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wb_we = 1'b0;
  logic [AW-1:0] wb_addr = '0;
  logic [DW-1:0] wb_data = '0;
  logic          ld_req = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [DW-1:0] ld_data = '0;
  logic          ld_ack, stall_req, rf_we, err;
  logic [AW-1:0] rf_addr;
  logic [DW-1:0] rf_data;

  int n_cmp = 0;
  int n_fail = 0;

  // Model: current visible outputs plus the count of WB wins suffered by a pending loader.
  logic          m_we, m_ack, m_stall, m_err;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  int            m_wait;

  regfile_write_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst_n(rst_n), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ack(ld_ack),
    .stall_req(stall_req), .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data), .err(err)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_we = 1'b0; m_ack = 1'b0; m_stall = 1'b0; m_err = 1'b0;
    m_addr = '0; m_data = '0; m_wait = 0;
  endtask

  task automatic model_step();
    bit pending;
    pending = ld_req && !m_ack;
    m_err = m_err | (wb_we & m_stall);
    if (wb_we) begin
      m_we = (wb_addr != 0); m_addr = wb_addr; m_data = wb_data; m_ack = 1'b0;
      m_wait = pending ? ((m_wait < 15) ? m_wait + 1 : 15) : 0;
    end else if (pending) begin
      m_we = (ld_addr != 0); m_addr = ld_addr; m_data = ld_data; m_ack = 1'b1;
      m_wait = 0;
    end else begin
      m_we = 1'b0; m_ack = 1'b0; m_wait = 0;
    end
    m_stall = (m_wait >= MW);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; wb_we = 1'b0; ld_req = 1'b0;
    wb_addr = '0; wb_data = '0; ld_addr = '0; ld_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      tick();
      n_cmp++;
      if ({rf_we, ld_ack, stall_req, err, rf_addr, rf_data} !== 42'd0) begin
        n_fail++;
        $display("FAIL reset_idle cyc=%0d got=%h want=0", i,
                 {rf_we, ld_ack, stall_req, err, rf_addr, rf_data});
      end
    end
  endtask

  task automatic test_loader_single();
    logic [41:0] exp [2];
    do_reset();
    exp[0] = {1'b1, 1'b1, 1'b0, 1'b0, 6'd3, 32'd4};
    exp[1] = {1'b0, 1'b0, 1'b0, 1'b0, 6'd3, 32'd4};
    ld_req = 1'b1; ld_addr = 6'd3; ld_data = 32'd4;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++;
      if ({rf_we, ld_ack, stall_req, err, rf_addr, rf_data} !== exp[i]) begin
        n_fail++;
        $display("FAIL loader_single cyc=%0d got=%h want=%h", i,
                 {rf_we, ld_ack, stall_req, err, rf_addr, rf_data}, exp[i]);
      end
    end
    ld_req = 1'b0;
  endtask

  task automatic test_wb_priority();
    logic [41:0] exp [4];
    do_reset();
    exp[0] = {1'b1, 1'b0, 1'b0, 1'b0, 6'd5, 32'hA5};
    exp[1] = exp[0];
    exp[2] = {1'b1, 1'b1, 1'b0, 1'b0, 6'd7, 32'h77};
    exp[3] = {1'b0, 1'b0, 1'b0, 1'b0, 6'd7, 32'h77};
    wb_we = 1'b1; wb_addr = 6'd5; wb_data = 32'hA5;
    ld_req = 1'b1; ld_addr = 6'd7; ld_data = 32'h77;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) wb_we = 1'b0;
      tick();
      n_cmp++;
      if ({rf_we, ld_ack, stall_req, err, rf_addr, rf_data} !== exp[i]) begin
        n_fail++;
        $display("FAIL wb_priority cyc=%0d got=%h want=%h", i,
                 {rf_we, ld_ack, stall_req, err, rf_addr, rf_data}, exp[i]);
      end
    end
    ld_req = 1'b0;
  endtask

  task automatic test_stall_err();
    logic [41:0] exp [7];
    do_reset();
    for (int i = 0; i < 3; i++) exp[i] = {1'b1, 1'b0, 1'b0, 1'b0, 6'd9, 32'd1};
    exp[3] = {1'b1, 1'b0, 1'b1, 1'b0, 6'd9, 32'd1};
    exp[4] = {1'b1, 1'b0, 1'b1, 1'b1, 6'd9, 32'd1};
    exp[5] = {1'b1, 1'b1, 1'b0, 1'b1, 6'd10, 32'd2};
    exp[6] = {1'b0, 1'b0, 1'b0, 1'b1, 6'd10, 32'd2};
    wb_we = 1'b1; wb_addr = 6'd9; wb_data = 32'd1;
    ld_req = 1'b1; ld_addr = 6'd10; ld_data = 32'd2;
    for (int i = 0; i < 7; i++) begin
      if (i == 5) wb_we = 1'b0;
      tick();
      n_cmp++;
      if ({rf_we, ld_ack, stall_req, err, rf_addr, rf_data} !== exp[i]) begin
        n_fail++;
        $display("FAIL stall_err cyc=%0d got=%h want=%h", i,
                 {rf_we, ld_ack, stall_req, err, rf_addr, rf_data}, exp[i]);
      end
    end
    ld_req = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if (err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_sticky got=%b want=1", err);
    end
    do_reset();
    #1;
    n_cmp++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_reset got=%b want=0", err);
    end
  endtask

  task automatic test_addr_zero();
    logic [41:0] exp [4];
    do_reset();
    exp[0] = {1'b0, 1'b1, 1'b0, 1'b0, 6'd0, 32'hFF};
    exp[1] = {1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 32'hFF};
    exp[2] = {1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 32'h11};
    exp[3] = {1'b1, 1'b0, 1'b0, 1'b0, 6'd2, 32'h22};
    ld_req = 1'b1; ld_addr = 6'd0; ld_data = 32'hFF;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) begin ld_req = 1'b0; wb_we = 1'b1; wb_addr = 6'd0; wb_data = 32'h11; end
      if (i == 3) begin wb_addr = 6'd2; wb_data = 32'h22; end
      tick();
      n_cmp++;
      if ({rf_we, ld_ack, stall_req, err, rf_addr, rf_data} !== exp[i]) begin
        n_fail++;
        $display("FAIL addr_zero cyc=%0d got=%h want=%h", i,
                 {rf_we, ld_ack, stall_req, err, rf_addr, rf_data}, exp[i]);
      end
    end
    wb_we = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    wb_we = 1'b1; wb_addr = 6'd13; wb_data = 32'd4;
    ld_req = 1'b1; ld_addr = 6'd12; ld_data = 32'd3;
    tick();
    n_cmp++;
    if ({rf_we, ld_ack, stall_req, err, rf_addr, rf_data} !== {4'b1000, 6'd13, 32'd4}) begin
      n_fail++;
      $display("FAIL reset_mid_pre got=%h", {rf_we, ld_ack, stall_req, err, rf_addr, rf_data});
    end
    wb_we = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({rf_we, ld_ack, stall_req, err, rf_addr, rf_data} !== 42'd0) begin
      n_fail++;
      $display("FAIL reset_mid_async got=%h want=0", {rf_we, ld_ack, stall_req, err, rf_addr, rf_data});
    end
    ld_req = 1'b0;
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if ({rf_we, ld_ack, stall_req, err, rf_addr, rf_data} !== 42'd0) begin
        n_fail++;
        $display("FAIL reset_mid_after cyc=%0d got=%h want=0", i,
                 {rf_we, ld_ack, stall_req, err, rf_addr, rf_data});
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if (i == 400) do_reset();
      if (m_stall) wb_we = ($urandom_range(0, 7) == 0);
      else         wb_we = ($urandom_range(0, 99) < 60);
      if (ld_req && !m_ack) ld_req = ($urandom_range(0, 19) != 0);
      else                  ld_req = ($urandom_range(0, 99) < 40);
      wb_addr = AW'($urandom_range(0, 7)); wb_data = $urandom;
      ld_addr = AW'($urandom_range(0, 7)); ld_data = $urandom;
      tick();
      n_cmp++;
      if ({rf_we, ld_ack, stall_req, err, rf_addr, rf_data} !==
          {m_we, m_ack, m_stall, m_err, m_addr, m_data}) begin
        n_fail++;
        $display("FAIL random cyc=%0d got=%h want=%h", i,
                 {rf_we, ld_ack, stall_req, err, rf_addr, rf_data},
                 {m_we, m_ack, m_stall, m_err, m_addr, m_data});
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_loader_single();
    test_wb_priority();
    test_stall_err();
    test_addr_zero();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
